// File: rtl/ref_buf_from_axi_read_master_if.sv
// AXI4 read-address and read-data channels for the reference-block read master.
interface ref_buf_from_axi_read_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 512
);
  logic              arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic              rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/ref_buf_from_axi_read_master.sv
// Fetches one packed 8x8 reference block (BEATS-beat AXI4 INCR burst) from the DPB.
// Optional REF_RD_RLAST_CHECK_EN adds a sticky rlast_err output for rlast/beat-count disagreement.
module ref_buf_from_axi_read_master #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 512,
  parameter int unsigned BEATS        = 3,
  parameter int unsigned XY_W         = 9,
  parameter int unsigned CTB_8X8_LOG2 = 3,
  parameter int unsigned IU_ROW_SHIFT = 22,
  parameter int unsigned IU_SHIFT     = 14,
  parameter int unsigned BU_ROW_SHIFT = 11,
  parameter int unsigned BU_SHIFT     = 8,
  parameter int unsigned AR_SIZE      = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [XY_W-1:0]           req_x,
  input  logic [XY_W-1:0]           req_y,
  input  logic [ADDR_W-1:0]         req_base_addr,
  ref_buf_from_axi_read_master_if.master axi,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BEATS*DATA_W-1:0]   out_data,
  output logic [XY_W-1:0]           out_x,
  output logic [XY_W-1:0]           out_y,
  output logic                      out_err
`ifdef REF_RD_RLAST_CHECK_EN
  ,
  output logic                      rlast_err
`endif
);

  localparam int unsigned C     = CTB_8X8_LOG2;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_OUT} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q;
  logic                      out_err_q;
  logic [ADDR_W-1:0]         araddr_q;
  logic [XY_W-1:0]           x_q, y_q;
  logic [BEATS*DATA_W-1:0]   data_q;
  logic [ADDR_W-1:0]         x_ctu, y_ctu, x_bu, y_bu, addr_calc;
  logic                      req_fire, ar_fire, beat_fire, last_beat;

  // IU (CTU) and BU (8x8 inside CTU) components of the DPB address
  always_comb begin
    x_ctu     = ADDR_W'(req_x >> C);
    y_ctu     = ADDR_W'(req_y >> C);
    x_bu      = ADDR_W'(req_x[C-1:0]);
    y_bu      = ADDR_W'(req_y[C-1:0]);
    addr_calc = req_base_addr + (y_ctu << IU_ROW_SHIFT) + (x_ctu << IU_SHIFT)
              + (y_bu << BU_ROW_SHIFT) + (x_bu << BU_SHIFT);
  end

  assign req_fire  = req_valid && req_ready;
  assign ar_fire   = axi.arvalid && axi.arready;
  assign beat_fire = axi.rvalid && axi.rready;
  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // arvalid/rready/out_valid decode the registered state, so they change only on clock edges
  always_comb begin
    state_d     = state_q;
    req_ready   = 1'b0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    out_valid   = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = reset;
        if (req_valid) state_d = S_ADDR;
      end
      S_ADDR: begin
        axi.arvalid = 1'b1;
        if (axi.arready) state_d = S_DATA;
      end
      S_DATA: begin
        axi.rready = 1'b1;
        if (beat_fire && last_beat) state_d = S_OUT;
      end
      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      out_err_q <= 1'b0;
    end else if (ar_fire) begin
      cnt_q     <= '0;
      out_err_q <= 1'b0;
    end else if (beat_fire) begin
      cnt_q     <= cnt_q + 1'b1;
      out_err_q <= out_err_q | (|axi.rresp);
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      araddr_q <= addr_calc;
      x_q      <= req_x;
      y_q      <= req_y;
    end
    for (int unsigned k = 0; k < BEATS; k++) begin
      if (beat_fire && cnt_q == CNT_W'(k)) data_q[k*DATA_W +: DATA_W] <= axi.rdata;
    end
  end

`ifdef REF_RD_RLAST_CHECK_EN
  logic rlast_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                     rlast_err_q <= 1'b0;
    else if (beat_fire && (axi.rlast != last_beat)) rlast_err_q <= 1'b1;
  end

  assign rlast_err = rlast_err_q;
`endif

  assign axi.arid    = 1'b0;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = 8'(BEATS - 1);
  assign axi.arsize  = 3'(AR_SIZE);
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 1'b0;
  assign axi.arcache = 4'b0011;
  assign axi.arprot  = 3'b000;

  assign out_data = data_q;
  assign out_x    = x_q;
  assign out_y    = y_q;
  assign out_err  = out_err_q;

endmodule

// File: tb/tb_ref_buf_from_axi_read_master.sv
// Randomized bench for ref_buf_from_axi_read_master with a transaction-level reference model.
module tb_ref_buf_from_axi_read_master;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 512;
  localparam int unsigned NB = 3;
  localparam int unsigned XW = 9;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [XW-1:0]     req_x = '0, req_y = '0;
  logic [AW-1:0]     req_base_addr = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [NB*DW-1:0]  out_data;
  logic [XW-1:0]     out_x, out_y;
  logic              out_err;
`ifdef REF_RD_RLAST_CHECK_EN
  logic              rlast_err;
`endif

  ref_buf_from_axi_read_master_if #(.ADDR_W(AW), .DATA_W(DW)) axi_if ();

  ref_buf_from_axi_read_master dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .req_base_addr(req_base_addr), .axi(axi_if),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_x(out_x), .out_y(out_y), .out_err(out_err)
`ifdef REF_RD_RLAST_CHECK_EN
    , .rlast_err(rlast_err)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    total++;
    bad++;
    $display("FAIL timeout_%s got=expired want=handshake", nm);
  endtask

  // Reference address: plain integer arithmetic on CTU/8x8 coordinates, modulo 2^32
  function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] base, input int x, input int y);
    longint unsigned a;
    a = longint'(base) + longint'(y / 8) * 4194304 + longint'(x / 8) * 16384
      + longint'(y % 8) * 2048 + longint'(x % 8) * 256;
    return a[AW-1:0];
  endfunction

  // Transaction model: one outstanding block, tracked by what the bus has done so far
  bit            m_busy, m_apend, m_deliv, m_err, m_rl_err;
  int            m_got;
  logic [AW-1:0] m_addr;
  logic [XW-1:0] m_x, m_y;
  logic [DW-1:0] m_beat [NB];

  always @(negedge clk) begin
    bit req_f, ar_f, r_f, o_f;
    if (!reset) begin
      chk("rst_arvalid", axi_if.arvalid, 1'b0);
      chk("rst_rready", axi_if.rready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_err", out_err, 1'b0);
      chk("rst_req_ready", req_ready, 1'b0);
`ifdef REF_RD_RLAST_CHECK_EN
      chk("rst_rlast_err", rlast_err, 1'b0);
`endif
      m_busy = 0; m_apend = 0; m_deliv = 0; m_err = 0; m_rl_err = 0; m_got = 0;
    end else begin
      chk("req_ready", req_ready, !m_busy);
      chk("arvalid", axi_if.arvalid, m_apend);
      if (m_apend) chk("araddr", axi_if.araddr, m_addr);
      chk("rready", axi_if.rready, m_busy && !m_apend && !m_deliv);
      chk("out_valid", out_valid, m_deliv);
      if (m_deliv) begin
        chk("out_x", out_x, m_x);
        chk("out_y", out_y, m_y);
        chk("out_err", out_err, m_err);
        for (int k = 0; k < NB; k++)
          chk($sformatf("out_beat%0d", k), out_data[k*DW +: DW], m_beat[k]);
      end
      chk("arid", axi_if.arid, 1'b0);
      chk("arlen", axi_if.arlen, NB - 1);
      chk("arsize", axi_if.arsize, 3'd6);
      chk("arburst", axi_if.arburst, 2'b01);
      chk("arlock", axi_if.arlock, 1'b0);
      chk("arcache", axi_if.arcache, 4'b0011);
      chk("arprot", axi_if.arprot, 3'b000);
`ifdef REF_RD_RLAST_CHECK_EN
      chk("rlast_err", rlast_err, m_rl_err);
`endif
      req_f = req_valid && !m_busy;
      ar_f  = m_apend && axi_if.arready;
      r_f   = axi_if.rvalid && m_busy && !m_apend && !m_deliv;
      o_f   = m_deliv && out_ready;
      if (req_f) begin
        m_busy = 1; m_apend = 1;
        m_addr = model_addr(req_base_addr, int'(req_x), int'(req_y));
        m_x = req_x; m_y = req_y;
      end
      if (ar_f) begin
        m_apend = 0; m_got = 0; m_err = 0;
      end
      if (r_f) begin
        m_beat[m_got] = axi_if.rdata;
        if (axi_if.rresp != 2'b00) m_err = 1;
        if (axi_if.rlast != (m_got == NB - 1)) m_rl_err = 1;
        m_got++;
        if (m_got == NB) m_deliv = 1;
      end
      if (o_f) begin
        m_deliv = 0; m_busy = 0;
      end
    end
  end

  logic [AW-1:0]    last_araddr;
  logic [NB*DW-1:0] last_data;
  logic             last_err;

  task automatic do_block(input logic [XW-1:0] x, input logic [XW-1:0] y, input logic [AW-1:0] base,
                          input int ar_dly, input bit gap, input int hold, input int err_beat,
                          input int rlast_beat, input bit fixed_data, input int abort_beat);
    logic [DW-1:0] beats [NB];
    logic [3:0]    nib;
    int            n;
    for (int k = 0; k < NB; k++) begin
      if (fixed_data) begin
        nib = 4'hA + 4'(k);
        beats[k] = {(DW/4){nib}};
      end else begin
        for (int i = 0; i < DW/32; i++) beats[k][i*32 +: 32] = $urandom;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b1; req_x = x; req_y = y; req_base_addr = base;
    axi_if.arready = (ar_dly == 0);
    out_ready = (hold == 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 100);
    if (!req_ready) begin tmo("req"); req_valid = 1'b0; return; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (ar_dly > 0) begin
      repeat (ar_dly) @(posedge clk);
      #1 axi_if.arready = 1'b1;
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!(axi_if.arvalid && axi_if.arready) && n < 100);
    if (!axi_if.arvalid) begin tmo("ar"); axi_if.arready = 1'b0; return; end
    last_araddr = axi_if.araddr;
    @(posedge clk); #1;
    axi_if.arready = 1'b0;
    for (int k = 0; k < NB; k++) begin
      if (gap && k > 0) begin
        axi_if.rvalid = 1'b0;
        @(posedge clk); #1;
      end
      axi_if.rvalid = 1'b1;
      axi_if.rdata  = beats[k];
      axi_if.rresp  = (k == err_beat) ? 2'b10 : 2'b00;
      axi_if.rlast  = (k == rlast_beat);
      if (k == abort_beat) begin
        #3 reset = 1'b0;
        #1;
        chk("async_arvalid", axi_if.arvalid, 1'b0);
        chk("async_rready", axi_if.rready, 1'b0);
        chk("async_out_valid", out_valid, 1'b0);
        chk("async_out_err", out_err, 1'b0);
        chk("async_req_ready", req_ready, 1'b0);
        axi_if.rvalid = 1'b0; axi_if.rlast = 1'b0; axi_if.rresp = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk); #2 reset = 1'b1;
        return;
      end
      n = 0;
      do begin @(negedge clk); n++; end while (!axi_if.rready && n < 100);
      if (!axi_if.rready) begin tmo("r"); axi_if.rvalid = 1'b0; return; end
      @(posedge clk); #1;
    end
    axi_if.rvalid = 1'b0; axi_if.rlast = 1'b0; axi_if.rresp = 2'b00;
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    if (!out_valid) begin tmo("out"); return; end
    last_data = out_data;
    last_err  = out_err;
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1 out_ready = 1'b1;
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!(out_valid && out_ready) && n < 100);
    if (!out_valid) begin tmo("out_hs"); out_ready = 1'b0; return; end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    axi_if.arready = 1'b0; axi_if.rid = 1'b0; axi_if.rdata = '0;
    axi_if.rresp = 2'b00; axi_if.rlast = 1'b0; axi_if.rvalid = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    // Address layout and fixed-pattern data, always-ready slave
    do_block(9'd9, 9'd10, 32'h1000_0000, 0, 0, 0, -1, NB-1, 1, -1);
    chk("lit_araddr", last_araddr, 32'h1040_5100);
    chk("lit_beat0", last_data[0 +: DW], {(DW/4){4'hA}});
    chk("lit_beat1", last_data[DW +: DW], {(DW/4){4'hB}});
    chk("lit_beat2", last_data[2*DW +: DW], {(DW/4){4'hC}});
    chk("lit_err_ok", last_err, 1'b0);

    // Backpressure on every channel
    do_block(9'd37, 9'd200, 32'h2345_6780, 5, 1, 4, -1, NB-1, 0, -1);

    // Error response on beat 1 only, then a clean block
    do_block(9'd3, 9'd4, 32'h0800_0000, 1, 0, 1, 1, NB-1, 0, -1);
    chk("lit_err_set", last_err, 1'b1);
    do_block(9'd3, 9'd5, 32'h0800_0000, 0, 0, 0, -1, NB-1, 0, -1);
    chk("lit_err_clr", last_err, 1'b0);

    // Reset during beat 1, then recovery
    do_block(9'd100, 9'd50, 32'hFFFF_0000, 0, 0, 0, -1, NB-1, 0, 1);
    do_block(9'd511, 9'd511, 32'hFFF0_0000, 0, 0, 0, -1, NB-1, 1, -1);
    chk("lit_after_rst", last_data[2*DW +: DW], {(DW/4){4'hC}});

`ifdef REF_RD_RLAST_CHECK_EN
    do_block(9'd1, 9'd2, 32'h0000_1000, 0, 0, 0, -1, 1, 1, -1);
    chk("lit_rlast_err", rlast_err, 1'b1);
    chk("lit_rlast_blk", last_data[2*DW +: DW], {(DW/4){4'hC}});
    do_block(9'd1, 9'd3, 32'h0000_1000, 0, 0, 0, -1, NB-1, 0, -1);
    chk("lit_rlast_sticky", rlast_err, 1'b1);
`endif

    for (int i = 0; i < 24; i++) begin
      int eb;
      eb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NB-1)) : -1;
      do_block(XW'($urandom_range(0, 511)), XW'($urandom_range(0, 511)), $urandom,
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
               eb, NB-1, 0, -1);
    end

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog got=running want=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ref_buf_from_axi_read_master.md
Name: ref_buf_from_axi_read_master

Overview:
AXI4 read master that fetches one reconstructed 8x8 reference block (luma plus Cb/Cr, pre-packed across BEATS data beats) from the DPB in external memory. It sits between the reference-cache fill logic, which issues block requests, and the AXI interconnect. It is the read-side counterpart of the DPB write path and uses the same IU/BU address layout. It returns the raw concatenated beats plus the block coordinates to the cache fill logic.

Parameters:
ADDR_W, 32, AXI address width.
DATA_W, 512, AXI read data width (bits).
BEATS, 3, beats per block; arlen = BEATS-1. Legal range 1..8.
XY_W, 9, width of the 8x8-unit X/Y coordinate.
CTB_8X8_LOG2, 3, log2 of 8x8 units per CTU side (64x64 CTU).
IU_ROW_SHIFT, 22, byte shift per CTU row.
IU_SHIFT, 14, byte shift per CTU column.
BU_ROW_SHIFT, 11, byte shift per 8x8 row inside a CTU.
BU_SHIFT, 8, byte shift per 8x8 column inside a CTU.
AR_SIZE, 6, arsize code (64 bytes per beat).

Ports:
clk  in  1  clock.
reset  in  1  asynchronous, active-low reset.
req_valid  in  1  block request valid.
req_ready  out  1  request accepted when high together with req_valid.
req_x  in  XY_W  block X in 8x8 units.
req_y  in  XY_W  block Y in 8x8 units.
req_base_addr  in  ADDR_W  DPB picture base address.
axi_arid  out  1  constant 0.
axi_araddr  out  ADDR_W  burst address.
axi_arlen  out  8  constant BEATS-1.
axi_arsize  out  3  constant AR_SIZE.
axi_arburst  out  2  constant INCR (2'b01).
axi_arlock/axi_arcache/axi_arprot  out  1/4/3  constants 0 / 4'b0011 / 3'b000.
axi_arvalid  out  1  address valid.
axi_arready  in  1  address ready.
axi_rid  in  1  ignored.
axi_rdata  in  DATA_W  read data.
axi_rresp  in  2  read response.
axi_rlast  in  1  last beat.
axi_rvalid  in  1  data valid.
axi_rready  out  1  data ready.
out_valid  out  1  block available.
out_ready  in  1  consumer accepts the block.
out_data  out  BEATS*DATA_W  beat k is in [k*DATA_W +: DATA_W].
out_x, out_y  out  XY_W  coordinates of the returned block.
out_err  out  1  at least one beat of this block had rresp != 0.

Behaviour:
- Reset (reset low, async): state IDLE; arvalid, rready, out_valid, out_err = 0; beat counter = 0; req_ready = 0 while reset is asserted. out_data, araddr, out_x, out_y are don't-care.
- State IDLE: req_ready = 1 (combinational, IDLE only). On req_valid: latch x, y and base; register araddr; arvalid <= 1; go to ADDR.
- Address, ADDR_W-bit modulo: base + (y>>C << IU_ROW_SHIFT) + (x>>C << IU_SHIFT) + (y[C-1:0] << BU_ROW_SHIFT) + (x[C-1:0] << BU_SHIFT), where C = CTB_8X8_LOG2.
- State ADDR: hold arvalid and araddr stable until arready. On arready: arvalid <= 0; rready <= 1; cnt <= 0; out_err <= 0; go to DATA.
- State DATA: on each rvalid && rready, store rdata into beat slot cnt, OR (rresp != 0) into out_err, and increment cnt. On the beat with cnt == BEATS-1: rready <= 0; out_valid <= 1; go to OUT.
- State OUT: out_valid, out_data, out_x, out_y and out_err stay stable until out_ready. On out_ready: out_valid <= 0; go to IDLE.
- rready is never high outside DATA. Only one burst is outstanding at a time.
- Minimum latency with an always-ready slave: req accept to arvalid is 1 cycle. Last R beat to out_valid is 1 cycle. Minimum request-to-request period is BEATS+3 cycles.
- Error beats are stored and counted like good beats. The burst is never retried.
- Reset mid-burst returns to IDLE immediately. Any R beats still in flight after reset are the system's responsibility and are not tracked.

Optional Feature:
Macro REF_RD_RLAST_CHECK_EN.
- Defined: adds output rlast_err (1 bit, sticky, cleared only by reset). It is set when rlast = 1 on a beat with cnt != BEATS-1, or rlast = 0 on the beat with cnt == BEATS-1. Beat counting, and therefore completion, still follows cnt only.
- Not defined: the rlast_err port and its logic are absent, and axi_rlast is ignored.

Test Plan:
- Address: base=0x1000_0000, x=9, y=10 -> araddr=0x1040_5100, arlen=2, arsize=6, arburst=1.
- Full transfer: always-ready slave, beats 0xA..A, 0xB..B, 0xC..C -> out_data={C,B,A}; out_valid asserted 1 cycle after the last beat; out_err=0.
- Backpressure: arready delayed 5 cycles, rvalid gapped every other cycle, out_ready held low 4 cycles -> araddr and out_data stay stable, req_ready=0 throughout, no beat lost.
- Error: rresp=2'b10 on beat 1 only -> out_err=1 for that block; the next block with OKAY beats -> out_err=0.
- Reset: reset driven low during beat 1 of DATA -> all outputs return to reset values asynchronously; after release a new request completes correctly.
- REF_RD_RLAST_CHECK_EN: rlast on beat 1 of 3 -> rlast_err=1 and remains set; block is still delivered after beat 2.
